// File: rtl/dbg_mem_dump_reader.sv
// Debug read-back engine: walks IMEM, then DMEM, then the register file
// and hands each word to the logic-analyzer side over a valid/ack handshake.
module dbg_mem_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  out_ack,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_sel,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [1:0]            rd_sel,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam logic [ADDR_WIDTH-1:0] IMEM_LAST = ADDR_WIDTH'(IMEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DMEM_LAST = ADDR_WIDTH'(DMEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] REG_LAST  = ADDR_WIDTH'(REG_COUNT - 1);

    localparam logic [1:0] SEL_IMEM = 2'd0;
    localparam logic [1:0] SEL_DMEM = 2'd1;
    localparam logic [1:0] SEL_REGS = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        PRESENT,
        DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              sel_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [1:0]              out_sel_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    rd_en_q;
    logic [1:0]              rd_sel_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;

    logic [ADDR_WIDTH-1:0]   last_addr_d;
    logic                    region_end_d;
    logic                    dump_end_d;
    logic [1:0]              sel_d;
    logic [ADDR_WIDTH-1:0]   addr_d;

    // Next scan position: step within a region, else move to the next one.
    always_comb begin
        last_addr_d  = REG_LAST;
        region_end_d = 1'b0;
        dump_end_d   = 1'b0;
        sel_d        = sel_q;
        addr_d       = addr_q + ADDR_WIDTH'(1);
        if (sel_q == SEL_IMEM) begin
            last_addr_d = IMEM_LAST;
        end else if (sel_q == SEL_DMEM) begin
            last_addr_d = DMEM_LAST;
        end
        region_end_d = (addr_q == last_addr_d);
        dump_end_d   = region_end_d && (sel_q >= SEL_REGS);
        if (region_end_d) begin
            sel_d  = sel_q + 2'd1;
            addr_d = '0;
        end
    end

    // Scan FSM; every output is a register updated here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            addr_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_sel_q    <= '0;
            rd_addr_q   <= '0;
        end else if (abort && state_q != IDLE) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        state_q   <= REQ;
                        sel_q     <= SEL_IMEM;
                        addr_q    <= '0;
                        busy_q    <= 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_sel_q  <= SEL_IMEM;
                        rd_addr_q <= '0;
                    end
                end
                REQ: begin
                    rd_en_q <= 1'b0;
                    state_q <= CAPT;
                end
                CAPT: begin
                    out_data_q  <= rd_data;
                    out_sel_q   <= sel_q;
                    out_addr_q  <= addr_q;
                    out_valid_q <= 1'b1;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ack) begin
                        out_valid_q <= 1'b0;
                        if (dump_end_d) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sel_q     <= sel_d;
                            addr_q    <= addr_d;
                            rd_en_q   <= 1'b1;
                            rd_sel_q  <= sel_d;
                            rd_addr_q <= addr_d;
                            state_q   <= REQ;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_sel    = rd_sel_q;
    assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_dbg_mem_dump_reader.sv
// Directed bench for dbg_mem_dump_reader: full dumps, backpressure,
// region boundaries, abort, async reset and stray start/ack pulses.
module tb_dbg_mem_dump_reader;

    logic        CLK;
    logic        RST;
    logic        start;
    logic        abort;
    logic        out_ack;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic [4:0]  out_addr;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [1:0]  rd_sel;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checks;
    int errors;
    int rd_en_cnt;
    int done_cnt;

    typedef struct {
        int          hold;
        logic [1:0]  sel;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vec [64];

    dbg_mem_dump_reader #(
        .DATA_WIDTH(32),
        .IMEM_DEPTH(16),
        .DMEM_DEPTH(16),
        .REG_COUNT (32),
        .ADDR_WIDTH(5)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .abort    (abort),
        .out_ack  (out_ack),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_addr (out_addr),
        .busy     (busy),
        .done     (done),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(logic [1:0] s, logic [4:0] a);
        logic [31:0] w;
        case (s)
            2'd0:    w = 32'h0010_8093 + {27'd0, a};
            2'd1:    w = 32'hD000_0000 + {27'd0, a};
            default: w = {25'd0, a, 2'b00};
        endcase
        return w;
    endfunction

    // Storage model: one-cycle read latency, garbage when not strobed.
    always @(posedge CLK) begin
        if (rd_en) rd_data <= mem_word(rd_sel, rd_addr);
        else       rd_data <= 32'hDEAD_BEEF;
    end

    always @(posedge CLK) begin
        if (rd_en) rd_en_cnt <= rd_en_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(inout int n);
        while (!out_valid && n < 16) begin
            tick();
            n++;
        end
        chk("valid_wait", {63'd0, out_valid}, 64'd1);
    endtask

    // Start a dump and walk it; stop_at < 64 leaves that word presented.
    task automatic run_dump(bit stray, bit use_hold, int stop_at);
        int n;
        int c0;
        start = 1'b1;
        tick();
        start = stray;
        out_ack = stray;
        n = 1;
        wait_valid(n);
        chk("start_lat", n, 3);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("word%0d", i),
                {out_sel, out_addr, out_data},
                {vec[i].sel, vec[i].addr, vec[i].data});
            if (i == stop_at) begin
                out_ack = 1'b0;
                start = 1'b0;
                return;
            end
            if (use_hold && vec[i].hold > 0) begin
                out_ack = 1'b0;
                c0 = rd_en_cnt;
                repeat (vec[i].hold) tick();
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_data", out_data, vec[i].data);
                chk("hold_no_rd", rd_en_cnt, c0);
            end
            if (i == 63) begin
                start = 1'b0;
                out_ack = 1'b1;
                tick();
                out_ack = 1'b0;
                chk("done_pulse", {out_valid, done, busy}, 3'b011);
                tick();
                chk("done_end", {out_valid, done, busy}, 3'b000);
            end else begin
                out_ack = 1'b1;
                tick();
                out_ack = stray;
                chk("ack_drop", {63'd0, out_valid}, 64'd0);
                n = 1;
                wait_valid(n);
                chk("ack_lat", n, 3);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rd_en_cnt = 0;
        done_cnt  = 0;
        rd_data   = '0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ack   = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vec[i] = '{0, 2'd0, 5'(i), 32'h0010_8093 + 32'(i)};
            vec[16 + i] = '{0, 2'd1, 5'(i), 32'hD000_0000 + 32'(i)};
        end
        for (int i = 0; i < 32; i++) begin
            vec[32 + i] = '{0, 2'd2, 5'(i), 32'(i * 4)};
        end
        vec[5].hold = 10;

        RST = 1'b1;
        tick();
        tick();
        chk("reset_outs",
            {out_valid, out_data, out_sel, out_addr, busy, done, rd_en, rd_sel, rd_addr},
            64'd0);
        RST = 1'b0;
        tick();

        run_dump(1'b0, 1'b0, 64);
        chk("done_cnt_1", done_cnt, 1);

        out_ack = 1'b1;
        tick();
        tick();
        out_ack = 1'b0;
        chk("idle_ack", {out_valid, busy, rd_en}, 3'b000);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {busy, rd_en}, 2'b00);
        tick();
        chk("start_abort_idle2", {busy, rd_en}, 2'b00);

        run_dump(1'b1, 1'b1, 64);
        chk("done_cnt_2", done_cnt, 2);

        run_dump(1'b0, 1'b0, 19);
        out_ack = 1'b1;
        abort = 1'b1;
        tick();
        out_ack = 1'b0;
        abort = 1'b0;
        chk("abort_outs", {out_valid, busy, rd_en, done}, 4'b0000);
        repeat (3) tick();
        chk("abort_idle", {out_valid, busy, rd_en}, 3'b000);
        chk("abort_no_done", done_cnt, 2);

        run_dump(1'b0, 1'b0, 0);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        tick();
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_outs",
            {out_valid, out_data, out_sel, out_addr, busy, done, rd_en, rd_sel, rd_addr},
            64'd0);
        tick();
        tick();
        RST = 1'b0;
        tick();
        chk("rst_no_done", done_cnt, 2);

        run_dump(1'b1, 1'b0, 64);
        chk("done_cnt_3", done_cnt, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_mem_dump_reader.md
Name: dbg_mem_dump_reader

Overview:
- Read-back engine for the user-project debug path.
- On a start pulse it scans instruction memory, then data memory, then the register file. Each word goes to the logic-analyzer output side with a valid/ack handshake.
- It is the readback counterpart of the host-side LA write path that loads IMemory. It sits between the LA pins and the core's debug read ports.

Parameters:
- DATA_WIDTH, 32, word width of every scanned storage
- IMEM_DEPTH, 16, instruction memory words scanned
- DMEM_DEPTH, 16, data memory words scanned
- REG_COUNT, 32, register file entries scanned
- ADDR_WIDTH, 5, width of rd_addr/out_addr; must hold max(depth)-1

Ports:
- CLK  input  1  core clock
- RST  input  1  asynchronous, active-high reset
- start  input  1  begin a dump; sampled only in IDLE
- abort  input  1  cancel the dump in progress
- out_ack  input  1  host accepted the presented word
- out_valid  output  1  out_data/out_sel/out_addr are valid
- out_data  output  DATA_WIDTH  word read back
- out_sel  output  2  source: 0 IMEM, 1 DMEM, 2 REGS
- out_addr  output  ADDR_WIDTH  index within the source
- busy  output  1  high from leaving IDLE until back in IDLE
- done  output  1  one-cycle pulse after the last REGS word is acked
- rd_en  output  1  read strobe to storage
- rd_sel  output  2  storage select (encoding as out_sel)
- rd_addr  output  ADDR_WIDTH  read index
- rd_data  input  DATA_WIDTH  read data, valid exactly one cycle after rd_en

Behaviour:
- Reset (async, RST=1): state IDLE.
  - All outputs 0: out_valid, out_data, out_sel, out_addr, busy, done, rd_en, rd_sel, rd_addr.
  - Internal sel/addr cleared.
- FSM states: IDLE, REQ, CAPT, PRESENT, DONE.
- IDLE:
  - start=1 -> REQ, with sel=0, addr=0 and busy=1 from the next cycle.
  - start in any other state is ignored.
- REQ:
  - rd_en=1 for exactly one cycle, rd_sel=sel, rd_addr=addr -> CAPT.
- CAPT:
  - rd_data registered into out_data; out_sel=sel, out_addr=addr; out_valid=1 next cycle -> PRESENT.
- PRESENT:
  - out_valid held high; out_data/out_sel/out_addr held stable until out_ack=1.
  - out_ack sampled only while out_valid=1; ack in other states has no effect.
  - On ack, out_valid=0 next cycle.
  - If addr < depth(sel)-1: addr+1 -> REQ.
  - Else if sel<2: sel+1, addr=0 -> REQ.
  - Else -> DONE.
- DONE:
  - done=1 for one cycle, busy=0 next cycle -> IDLE.
- Per-word latency:
  - start to first out_valid: 3 cycles.
  - Ack to next out_valid: 3 cycles.
  - Minimum full dump (ack immediate): 64 words x 3 cycles + DONE.
- abort=1 in any non-IDLE state -> IDLE next cycle; out_valid=0, busy=0, rd_en=0, done not pulsed. abort has priority over out_ack in the same cycle.
- abort in IDLE: no effect. Simultaneous start+abort in IDLE: abort wins, stay IDLE.
- Async RST mid-dump: immediate return to reset values; no partial done.
- Depth boundaries: last IMEM index = IMEM_DEPTH-1, then DMEM index 0. No wrap within a region; addr never exceeds depth-1.
- rd_data is ignored outside CAPT.

Test Plan:
- Preload IMEM[i]=0x00108093+i, DMEM[i]=0xD000_0000+i, REG[i]=i*4. Pulse start, ack every valid immediately. Expect:
  - 64 words in order IMEM0..15, DMEM0..15, REGS0..31 with matching out_sel/out_addr/out_data.
  - First out_valid 3 cycles after start.
  - done single-cycle pulse after REGS31 ack; busy low after.
- Backpressure: hold out_ack=0 for 10 cycles on IMEM5 -> out_valid stays 1, out_data=0x00108098 stable, no rd_en pulses; release ack -> IMEM6 appears 3 cycles later.
- Region boundary: ack IMEM15 -> next word out_sel=1, out_addr=0; ack DMEM15 -> out_sel=2, out_addr=0.
- Abort while presenting DMEM3 with out_ack=1 same cycle -> IDLE next cycle, out_valid=0, busy=0, no done. A new start restarts at IMEM0.
- Assert RST asynchronously during CAPT -> all outputs 0 immediately. start while busy -> ignored, sequence unaffected.
- out_ack pulsed in IDLE and during REQ/CAPT -> no address advance; full 64-word sequence still complete.
